// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared types and constants for the LEGv8 multi-cycle control unit.
// Holds the FSM state enum, the opcode class enum, the casez opcode patterns,
// ALU/sign-extend codes and the per-class ALU field lookup.
package multicycle_pkg;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      TRAP
   } state_t;

   typedef enum logic [3:0] {
      CLS_NOP,
      CLS_AND,
      CLS_ORR,
      CLS_ADD,
      CLS_SUB,
      CLS_ADDI,
      CLS_SUBI,
      CLS_MOVZ,
      CLS_B,
      CLS_CBZ,
      CLS_LDUR,
      CLS_STUR,
      CLS_ILLEGAL
   } class_t;

   // Opcode patterns over instr[31:21]; '?' bits are ignored by casez.
   localparam logic [10:0] PAT_AND  = 11'b?0001010???;
   localparam logic [10:0] PAT_ORR  = 11'b?0101010???;
   localparam logic [10:0] PAT_ADD  = 11'b?0?01011???;
   localparam logic [10:0] PAT_SUB  = 11'b?1?01011???;
   localparam logic [10:0] PAT_ADDI = 11'b?0?10001???;
   localparam logic [10:0] PAT_SUBI = 11'b?1?10001???;
   localparam logic [10:0] PAT_MOVZ = 11'b110100101??;
   localparam logic [10:0] PAT_B    = 11'b?00101?????;
   localparam logic [10:0] PAT_CBZ  = 11'b?011010????;
   localparam logic [10:0] PAT_LDUR = 11'b??111000010;
   localparam logic [10:0] PAT_STUR = 11'b??111000000;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_ORR   = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;

   localparam logic [2:0] SIGN_ITYPE = 3'b000;
   localparam logic [2:0] SIGN_DTYPE = 3'b001;
   localparam logic [2:0] SIGN_BTYPE = 3'b010;
   localparam logic [2:0] SIGN_CBZ   = 3'b011;
   localparam logic [2:0] SIGN_MOVZ  = 3'b111;

   typedef struct packed {
      logic [3:0] aluop;
      logic [2:0] signop;
      logic       alusrc;
      logic       reg2loc;
   } alu_ctrl_t;

   // ALU-side datapath fields used while a class sits in EXEC/MEM; unused fields stay 0.
   function automatic alu_ctrl_t alu_ctrl(input class_t cls);
      alu_ctrl_t c;
      c = '0;
      case (cls)
         CLS_AND:  c.aluop = ALU_AND;
         CLS_ORR:  c.aluop = ALU_ORR;
         CLS_ADD:  c.aluop = ALU_ADD;
         CLS_SUB:  c.aluop = ALU_SUB;
         CLS_ADDI: begin c.aluop = ALU_ADD;   c.signop = SIGN_ITYPE; c.alusrc = 1'b1; end
         CLS_SUBI: begin c.aluop = ALU_SUB;   c.signop = SIGN_ITYPE; c.alusrc = 1'b1; end
         CLS_MOVZ: begin c.aluop = ALU_PASSB; c.signop = SIGN_MOVZ;  c.alusrc = 1'b1; end
         CLS_B:    c.signop = SIGN_BTYPE;
         CLS_CBZ:  begin c.aluop = ALU_PASSB; c.signop = SIGN_CBZ;   c.reg2loc = 1'b1; end
         CLS_LDUR: begin c.aluop = ALU_ADD;   c.signop = SIGN_DTYPE; c.alusrc = 1'b1; end
         CLS_STUR: begin
            c.aluop   = ALU_ADD;
            c.signop  = SIGN_DTYPE;
            c.alusrc  = 1'b1;
            c.reg2loc = 1'b1;
         end
         default:  c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/opcode_classifier.sv
// opcode_classifier: purely combinational LEGv8 opcode -> instruction class map.
// Opcode bits above bit 10 must be zero for any legal class.
module opcode_classifier
   import multicycle_pkg::*;
#(
   parameter int OPCODE_W = 11
)(
   input  logic [OPCODE_W-1:0] opcode,
   output class_t              cls
);

   logic [10:0] low;
   logic        hi_zero;

   // First matching pattern wins; anything unmatched is ILLEGAL.
   always_comb begin
      low     = opcode[10:0];
      hi_zero = ((opcode >> 11) == '0);
      cls     = CLS_ILLEGAL;
      if (hi_zero) begin
         casez (low)
            PAT_AND:  cls = CLS_AND;
            PAT_ORR:  cls = CLS_ORR;
            PAT_ADD:  cls = CLS_ADD;
            PAT_SUB:  cls = CLS_SUB;
            PAT_ADDI: cls = CLS_ADDI;
            PAT_SUBI: cls = CLS_SUBI;
            PAT_MOVZ: cls = CLS_MOVZ;
            PAT_B:    cls = CLS_B;
            PAT_CBZ:  cls = CLS_CBZ;
            PAT_LDUR: cls = CLS_LDUR;
            PAT_STUR: cls = CLS_STUR;
            default:  cls = CLS_ILLEGAL;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for the LEGv8 multi-cycle datapath,
// with IMEM/DMEM handshakes, PC/IR strobes and a retired-instruction counter.
// Build macro ILLEGAL_TRAP_EN: illegal opcodes park the FSM in TRAP (sticky trap output)
// until reset instead of being skipped.
module multicycle_control
   import multicycle_pkg::*;
#(
   parameter int OPCODE_W = 11,
   parameter int ALUOP_W  = 4,
   parameter int SIGNOP_W = 3,
   parameter int CNT_W    = 32
)(
   input  logic                CLK,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   output logic                imem_req,
   input  logic                imem_ack,
   input  logic                dmem_ack,
   input  logic                zero,
   output logic                ir_write,
   output logic                pc_write,
   output logic                reg2loc,
   output logic                alusrc,
   output logic                mem2reg,
   output logic                regwrite,
   output logic                memread,
   output logic                memwrite,
   output logic                branch,
   output logic                uncond_branch,
   output logic [ALUOP_W-1:0]  aluop,
   output logic [SIGNOP_W-1:0] signop,
   output logic [CNT_W-1:0]    retired,
   output logic                busy
`ifdef ILLEGAL_TRAP_EN
   ,output logic               trap
`endif
);

   state_t    state, next_state;
   class_t    class_q, cls_now, eff_class;
   alu_ctrl_t ctl;

   // The datapath itself picks the CBZ target from zero; the control sequence is the same
   // for taken and not-taken, so the flag is deliberately not consumed here.
   logic unused_zero;
   assign unused_zero = zero;

   opcode_classifier #(.OPCODE_W(OPCODE_W)) u_classifier (
      .opcode (opcode),
      .cls    (cls_now)
   );

   // In DECODE the class register is not yet loaded, so the live classification is used.
   assign eff_class = (state == DECODE) ? cls_now : class_q;
   assign ctl       = alu_ctrl(eff_class);

`ifdef ILLEGAL_TRAP_EN
   assign trap = (state == TRAP) && !reset;
`endif

   // State register.
   always_ff @(posedge CLK) begin
      if (reset) state <= FETCH;
      else       state <= next_state;
   end

   // Instruction class register, loaded once per instruction in DECODE.
   always_ff @(posedge CLK) begin
      if (reset)                class_q <= CLS_NOP;
      else if (state == DECODE) class_q <= cls_now;
   end

   // Retired counter: every PC update of a real instruction counts; skipped illegals do not.
   always_ff @(posedge CLK) begin
      if (reset)                                  retired <= '0;
      else if (pc_write && eff_class != CLS_ILLEGAL) retired <= retired + CNT_W'(1);
   end

   // Next-state and control outputs; everything is held at 0 while reset is asserted.
   always_comb begin
      next_state    = state;
      imem_req      = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      reg2loc       = 1'b0;
      alusrc        = 1'b0;
      mem2reg       = 1'b0;
      regwrite      = 1'b0;
      memread       = 1'b0;
      memwrite      = 1'b0;
      branch        = 1'b0;
      uncond_branch = 1'b0;
      aluop         = '0;
      signop        = '0;
      busy          = 1'b0;
      if (!reset) begin
         case (state)
            FETCH: begin
               imem_req = 1'b1;
               if (imem_ack) begin
                  ir_write   = 1'b1;
                  next_state = DECODE;
               end
            end
            DECODE: begin
               busy = 1'b1;
               if (cls_now == CLS_ILLEGAL) begin
`ifdef ILLEGAL_TRAP_EN
                  next_state = TRAP;
`else
                  pc_write   = 1'b1;
                  next_state = FETCH;
`endif
               end else begin
                  next_state = EXEC;
               end
            end
            EXEC: begin
               busy    = 1'b1;
               aluop   = ALUOP_W'(ctl.aluop);
               signop  = SIGNOP_W'(ctl.signop);
               alusrc  = ctl.alusrc;
               reg2loc = ctl.reg2loc;
               case (class_q)
                  CLS_B: begin
                     uncond_branch = 1'b1;
                     pc_write      = 1'b1;
                     next_state    = FETCH;
                  end
                  CLS_CBZ: begin
                     branch     = 1'b1;
                     pc_write   = 1'b1;
                     next_state = FETCH;
                  end
                  CLS_LDUR, CLS_STUR: next_state = MEM;
                  default:            next_state = WB;
               endcase
            end
            MEM: begin
               busy     = 1'b1;
               aluop    = ALUOP_W'(ctl.aluop);
               signop   = SIGNOP_W'(ctl.signop);
               alusrc   = ctl.alusrc;
               reg2loc  = ctl.reg2loc;
               memread  = (class_q == CLS_LDUR);
               memwrite = (class_q == CLS_STUR);
               if (dmem_ack) begin
                  if (class_q == CLS_LDUR) begin
                     next_state = WB;
                  end else begin
                     pc_write   = 1'b1;
                     next_state = FETCH;
                  end
               end
            end
            WB: begin
               busy       = 1'b1;
               regwrite   = 1'b1;
               pc_write   = 1'b1;
               mem2reg    = (class_q == CLS_LDUR);
               next_state = FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            TRAP: next_state = TRAP;
`endif
            default: next_state = FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed, table-driven bench for multicycle_control (CNT_W=4 so the
// retired counter wraps quickly). Build macro ILLEGAL_TRAP_EN selects the trap variant.
module tb_multicycle_control;

   localparam int K_ALU = 0;
   localparam int K_B   = 1;
   localparam int K_CBZ = 2;
   localparam int K_LD  = 3;
   localparam int K_ST  = 4;

   // Output pack: {imem_req, ir_write, pc_write, busy, regwrite, mem2reg, memread, memwrite,
   //               branch, uncond_branch, reg2loc, alusrc, aluop[3:0], signop[2:0]}
   localparam logic [18:0] FETCH_IDLE = {1'b1, 18'b0};
   localparam logic [18:0] FETCH_ACK  = {2'b11, 17'b0};
   localparam logic [18:0] DEC_PACK   = {3'b000, 1'b1, 15'b0};

   typedef struct {
      logic [10:0] op;
      logic        z;
      logic [3:0]  aop;
      logic [2:0]  sop;
      logic        asrc;
      logic        r2l;
      int          kind;
      string       name;
   } vec_t;

   logic        CLK;
   logic        reset;
   logic [10:0] opcode;
   logic        imem_req, imem_ack, dmem_ack, zero;
   logic        ir_write, pc_write, reg2loc, alusrc, mem2reg, regwrite;
   logic        memread, memwrite, branch, uncond_branch, busy;
   logic [3:0]  aluop;
   logic [2:0]  signop;
   logic [3:0]  retired;
`ifdef ILLEGAL_TRAP_EN
   logic        trap;
`endif
   logic [18:0] obs;

   int checks = 0;
   int errors = 0;

   multicycle_control #(
      .OPCODE_W (11),
      .ALUOP_W  (4),
      .SIGNOP_W (3),
      .CNT_W    (4)
   ) dut (
      .CLK           (CLK),
      .reset         (reset),
      .opcode        (opcode),
      .imem_req      (imem_req),
      .imem_ack      (imem_ack),
      .dmem_ack      (dmem_ack),
      .zero          (zero),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .reg2loc       (reg2loc),
      .alusrc        (alusrc),
      .mem2reg       (mem2reg),
      .regwrite      (regwrite),
      .memread       (memread),
      .memwrite      (memwrite),
      .branch        (branch),
      .uncond_branch (uncond_branch),
      .aluop         (aluop),
      .signop        (signop),
      .retired       (retired),
      .busy          (busy)
`ifdef ILLEGAL_TRAP_EN
      ,.trap         (trap)
`endif
   );

   assign obs = {imem_req, ir_write, pc_write, busy, regwrite, mem2reg, memread, memwrite,
                 branch, uncond_branch, reg2loc, alusrc, aluop, signop};

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Advance to the next low phase, drive inputs, and let the combinational outputs settle.
   task automatic step(input logic ia, input logic da, input logic rs);
      @(negedge CLK);
      imem_ack = ia;
      dmem_ack = da;
      reset    = rs;
      #1;
   endtask

   vec_t        tbl[12];
   vec_t        v;
   logic [3:0]  exp_ret;
   logic        pcw, ld, st;

   initial begin
      tbl[0]  = '{11'b10001010000, 1'b0, 4'b0000, 3'b000, 1'b0, 1'b0, K_ALU, "AND"};
      tbl[1]  = '{11'b10101010000, 1'b0, 4'b0001, 3'b000, 1'b0, 1'b0, K_ALU, "ORR"};
      tbl[2]  = '{11'b10001011000, 1'b0, 4'b0010, 3'b000, 1'b0, 1'b0, K_ALU, "ADD"};
      tbl[3]  = '{11'b11001011000, 1'b0, 4'b0110, 3'b000, 1'b0, 1'b0, K_ALU, "SUB"};
      tbl[4]  = '{11'b10010001000, 1'b0, 4'b0010, 3'b000, 1'b1, 1'b0, K_ALU, "ADDI"};
      tbl[5]  = '{11'b11010001000, 1'b0, 4'b0110, 3'b000, 1'b1, 1'b0, K_ALU, "SUBI"};
      tbl[6]  = '{11'b11010010100, 1'b0, 4'b0111, 3'b111, 1'b1, 1'b0, K_ALU, "MOVZ"};
      tbl[7]  = '{11'b00010100000, 1'b0, 4'b0000, 3'b010, 1'b0, 1'b0, K_B,   "B"};
      tbl[8]  = '{11'b10110100000, 1'b1, 4'b0111, 3'b011, 1'b0, 1'b1, K_CBZ, "CBZ_Z1"};
      tbl[9]  = '{11'b10110100000, 1'b0, 4'b0111, 3'b011, 1'b0, 1'b1, K_CBZ, "CBZ_Z0"};
      tbl[10] = '{11'b11111000010, 1'b0, 4'b0010, 3'b001, 1'b1, 1'b0, K_LD,  "LDUR"};
      tbl[11] = '{11'b11111000000, 1'b0, 4'b0010, 3'b001, 1'b1, 1'b1, K_ST,  "STUR"};

      reset = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; zero = 1'b0; opcode = '0;

      // Reset: outputs quiet while asserted, then FETCH requesting with counter at 0.
      step(0, 0, 1); chk("reset_outputs", obs, 0);
      step(0, 0, 1); chk("reset_retired", retired, 0);
      step(0, 0, 0); chk("reset_fetch", obs, FETCH_IDLE);
      step(0, 0, 0); chk("fetch_hold", obs, FETCH_IDLE);
      step(0, 0, 0); chk("fetch_hold2", obs, FETCH_IDLE);

      // Table: every class with zero-wait acknowledges.
      exp_ret = 4'd0;
      for (int i = 0; i < 12; i++) begin
         v      = tbl[i];
         opcode = v.op;
         zero   = v.z;
         pcw    = (v.kind == K_B) || (v.kind == K_CBZ);
         ld     = (v.kind == K_LD);
         st     = (v.kind == K_ST);
         step(1, 0, 0);
         chk({v.name, "_fetch"}, obs, FETCH_ACK);
         chk({v.name, "_retired_before"}, retired, exp_ret);
         step(0, 0, 0);
         chk({v.name, "_decode"}, obs, DEC_PACK);
         step(0, 0, 0);
         chk({v.name, "_exec"}, obs, {1'b0, 1'b0, pcw, 1'b1, 4'b0000, (v.kind == K_CBZ),
                                      (v.kind == K_B), v.r2l, v.asrc, v.aop, v.sop});
         if (pcw) exp_ret = exp_ret + 4'd1;
         if (ld || st) begin
            step(0, 1, 0);
            chk({v.name, "_mem"}, obs, {1'b0, 1'b0, st, 1'b1, 1'b0, 1'b0, ld, st, 1'b0, 1'b0,
                                        v.r2l, v.asrc, v.aop, v.sop});
            if (st) exp_ret = exp_ret + 4'd1;
         end
         if (v.kind == K_ALU || ld) begin
            step(0, 0, 0);
            chk({v.name, "_wb"}, obs, {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, ld, 13'b0});
            exp_ret = exp_ret + 4'd1;
         end
      end
      step(0, 0, 0);
      chk("table_idle", obs, FETCH_IDLE);
      chk("table_retired", retired, 4'd12);

      // LDUR with three MEM cycles (ack on the third): seven cycles in total.
      step(0, 0, 1);
      opcode = 11'b11111000010;
      step(1, 0, 0); chk("ldw_fetch", obs, FETCH_ACK);
      step(0, 0, 0); chk("ldw_decode", obs, DEC_PACK);
      step(0, 0, 0); chk("ldw_exec", obs, {12'b0001_0000_0001, 4'b0010, 3'b001});
      for (int k = 0; k < 3; k++) begin
         step(0, (k == 2), 0);
         chk("ldw_mem", obs, {12'b0001_0010_0001, 4'b0010, 3'b001});
      end
      step(0, 0, 0); chk("ldw_wb", obs, {12'b0011_1100_0000, 7'b0});
      step(0, 0, 0); chk("ldw_idle", obs, FETCH_IDLE);
      chk("ldw_retired", retired, 4'd1);

      // Reset while a STUR waits in MEM: the store is abandoned without a PC update.
      opcode = 11'b11111000000;
      step(1, 0, 0); chk("strst_fetch", obs, FETCH_ACK);
      step(0, 0, 0); chk("strst_decode", obs, DEC_PACK);
      step(0, 0, 0); chk("strst_exec", obs, {12'b0001_0000_0011, 4'b0010, 3'b001});
      step(0, 0, 0); chk("strst_mem", obs, {12'b0001_0001_0011, 4'b0010, 3'b001});
      step(0, 0, 1); chk("strst_during_reset", obs, 0);
      step(0, 0, 0); chk("strst_after_reset", obs, FETCH_IDLE);
      chk("strst_retired", retired, 4'd0);

      // Illegal opcode.
      opcode = 11'b00000000000;
      step(1, 0, 0); chk("ill_fetch", obs, FETCH_ACK);
`ifdef ILLEGAL_TRAP_EN
      step(0, 0, 0); chk("ill_decode", obs, DEC_PACK);
      for (int k = 0; k < 20; k++) begin
         step((k % 2 == 0), (k % 3 == 0), 0);
         chk("trap_quiet", obs, 0);
         chk("trap_flag", trap, 1);
      end
      chk("trap_retired", retired, 4'd0);
      step(0, 0, 1); chk("trap_reset_outputs", obs, 0);
      step(0, 0, 0); chk("trap_cleared", trap, 0);
      chk("trap_fetch", obs, FETCH_IDLE);
`else
      step(0, 0, 0); chk("ill_decode_skip", obs, {3'b001, 1'b1, 15'b0});
      step(0, 0, 0); chk("ill_back_to_fetch", obs, FETCH_IDLE);
      chk("ill_retired", retired, 4'd0);
`endif

      // 16 ADDs from reset: the 4-bit counter wraps to 0.
      step(0, 0, 1);
      opcode = 11'b10001011000;
      for (int n = 0; n < 16; n++) begin
         step(1, 0, 0);
         chk("wrap_count", retired, n);
         step(0, 0, 0);
         step(0, 0, 0);
         step(0, 0, 0);
         chk("wrap_wb", obs, {12'b0011_1000_0000, 7'b0});
      end
      step(0, 0, 0);
      chk("wrap_retired", retired, 4'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
